// File: rtl/vote_collector.sv
// vote_collector: collects one vote per voter (7 voters) during a session that
// opens on start. The session closes when everyone has voted or the timer runs
// out. The closed ballot is then presented on people/absent with a one-cycle
// people_valid strobe.
module vote_collector #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       vote_valid,
    input  logic [2:0] voter_id,
    input  logic       vote_value,
    output logic       vote_ready,
    output logic       reject,
    output logic [6:0] people,
    output logic [6:0] absent,
    output logic       people_valid,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DONE
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [6:0] ballot;
    logic [6:0] mask;
    logic [6:0] ballot_next;
    logic [6:0] mask_next;
    logic [7:0] timer;
    logic [7:0] voter_sel;
    logic [7:0] mask_ext;
    logic       taken;
    logic       accept;
    logic       refuse;
    logic       close;

    // Vote qualification, ballot/mask update and next-state selection.
    // Voter id 7 is folded into the mask as a permanently "already voted"
    // slot, so illegal ids and duplicates are refused by the same test.
    always_comb begin
        state_next  = state;
        voter_sel   = 8'b1 << voter_id;
        mask_ext    = {1'b1, mask};
        taken       = mask_ext[voter_id];
        accept      = 1'b0;
        refuse      = 1'b0;
        close       = 1'b0;
        ballot_next = ballot;
        mask_next   = mask;

        if (state == COLLECT && !abort && vote_valid) begin
            accept = !taken;
            refuse = taken;
        end

        if (accept) begin
            ballot_next = (ballot & ~voter_sel[6:0]) |
                          (vote_value ? voter_sel[6:0] : 7'b0);
            mask_next   = mask | voter_sel[6:0];
        end

        if (state == COLLECT && !abort) begin
            close = (mask_next == 7'h7F) || (timer == 8'(TIMEOUT - 1));
        end

        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (close) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, session bookkeeping and the held result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ballot <= 7'b0;
            mask   <= 7'b0;
            timer  <= 8'd0;
            people <= 7'b0;
            absent <= 7'b0;
            reject <= 1'b0;
        end else begin
            state  <= state_next;
            reject <= refuse;
            if (state == IDLE && start && !abort) begin
                ballot <= 7'b0;
                mask   <= 7'b0;
                timer  <= 8'd0;
            end else if (state == COLLECT && !abort) begin
                ballot <= ballot_next;
                mask   <= mask_next;
                timer  <= timer + 8'd1;
                if (close) begin
                    people <= ballot_next;
                    absent <= ~mask_next;
                end
            end
        end
    end

    // Status outputs are decoded directly from the state.
    always_comb begin
        vote_ready   = (state == COLLECT);
        busy         = (state != IDLE);
        people_valid = (state == DONE);
    end

endmodule

// File: doc/vote_collector.md
# vote_collector

Sequential ballot-collection stage that sits directly upstream of the 7-voter majority block. It opens a voting session on `start` and accepts one vote per voter over a valid/ready handshake. It closes the session when all 7 voters have voted or a timeout expires, then presents the 7-bit ballot vector `people[6:0]` with a one-cycle `people_valid` strobe. The majority block consumes `people` combinationally.

## Interface
- `TIMEOUT`, default 16: number of COLLECT-state cycles before a forced close. Legal range is 2..255.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: open a session; sampled only in IDLE.
- `abort` input 1: cancel the current session; highest priority.
- `vote_valid` input 1: a vote is presented this cycle.
- `voter_id` input 3: voter index 0..6; value 7 is illegal.
- `vote_value` input 1: 1 = yes, 0 = no.
- `vote_ready` output 1: high only in COLLECT.
- `reject` output 1: one-cycle pulse after a refused vote.
- `people` output 7: closed ballot; bit i is voter i's vote, and absent voters read 0.
- `absent` output 7: bit i is 1 if voter i did not vote in the last closed session.
- `people_valid` output 1: one-cycle strobe; `people`/`absent` are updated.
- `busy` output 1: high in COLLECT and DONE.

## Operation
- Reset values:
  - State is IDLE.
  - `people`, `absent`, the internal ballot and the voted mask are 7'b0.
  - `vote_ready`, `reject`, `people_valid` and `busy` are 0.
  - The timer is 0.
- `rst` overrides everything, including mid-session. No `people_valid` is produced for a session cut off by reset.
- FSM has three states: IDLE, COLLECT and DONE.
- **IDLE**
  - `start`=1 and `abort`=0 → COLLECT at the next edge.
  - The same edge clears the ballot, the voted mask and the timer.
  - `vote_valid` is ignored; no `reject` is raised in IDLE.
- **COLLECT**
  - A handshake occurs at an edge where `vote_valid`=1 (`vote_ready` is 1 throughout COLLECT).
  - A vote is accepted if `voter_id`≤6 and `mask[voter_id]`=0. Acceptance writes `ballot[voter_id]`←`vote_value` and sets `mask[voter_id]`←1.
  - A vote is refused if `voter_id`=7, or if the voter already voted (duplicate). A refused vote leaves the ballot untouched. `reject`=1 in the following cycle only.
  - The timer increments by 1 every COLLECT cycle.
  - Close condition is either of:
    - the mask after this edge's update is 7'h7F, or
    - timer = `TIMEOUT`−1 at this edge.
  - A vote accepted on the closing edge is included in the ballot.
  - `start` in COLLECT is ignored.
- **Close edge** (COLLECT→DONE):
  - `people`←final ballot.
  - `absent`←~final mask.
  - `people_valid`←1.
- **DONE**
  - Lasts exactly one cycle, with `people_valid`=1.
  - Then → IDLE, with `people_valid`←0.
  - `start`, `vote_valid` and `abort` are all ignored in DONE.
- **abort** in COLLECT → IDLE at the next edge.
  - Any vote presented on that edge is discarded.
  - No `people_valid`; `people`/`absent` keep their previous values.
  - In IDLE, `abort` blocks `start`.
- `people` and `absent` hold their values until the next close.
- Widths:
  - The timer is 8 bits and never wraps: the close happens at `TIMEOUT`−1.
  - The voted count is implied by the mask; no arithmetic wider than the timer is needed.

## Timing
- `start` at edge E0 → `vote_ready`=1 from E0+ (the first COLLECT cycle).
- Accept latency: the vote is registered at the handshake edge.
- `reject` is asserted in the cycle after the refused edge.
- All-voted close:
  - Seventh distinct accept at edge Ek → `people_valid`=1 during cycle Ek+ (DONE).
  - IDLE after Ek+1.
  - `start` at Ek+1 is the earliest accepted restart.
- Timeout close:
  - COLLECT lasts exactly `TIMEOUT` cycles when not all 7 voters vote.
  - `people_valid` comes in cycle `TIMEOUT`+1 after the `start` edge.
- At most one vote per cycle.
- Back-to-back sessions: minimum period is 9 cycles (start, 7 votes, DONE).

## Test plan
- **Full session:** start, then ids 0..6 with values 1,1,1,1,0,0,0 on consecutive cycles → `people`=7'b0001111, `absent`=0, `people_valid` high for exactly 1 cycle, 1 cycle after the 7th vote.
- **Duplicate and illegal:** start; id 2=1; id 2=0; id 7=1 → `reject` pulses on the 2nd and 3rd votes, and `ballot[2]` stays 1. `TIMEOUT`=16 timeout → `people`=7'b0000100, `absent`=7'b1111011.
- **Timeout edge:** `TIMEOUT`=4; start; a vote for id 5=1 on the 4th COLLECT cycle → vote included, `people`=7'b0100000, `people_valid` in the 5th cycle after start.
- **Abort:** complete a session yielding 7'h7F; new start; 3 votes; abort → no `people_valid`, `people` remains 7'h7F, `vote_ready` is 0 next cycle, `busy` is 0.
- **Reset mid-session:** `rst` asserted after 4 votes → next cycle all outputs are 0 and `people` is 0; a following full session behaves as in the first scenario.
- **Ignored inputs:** `start` during COLLECT and DONE, and `vote_valid` in IDLE/DONE → no state change and no `reject`.
